// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM state codes,
// opcodes, ALU operation codes and datapath mux selects.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_IEXEC    = 4'd11,
        S_IWB      = 4'd12
    } state_t;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State following DECODE for a supported opcode; unsupported ones map to IDLE.
    function automatic state_t decode_target(input logic [5:0] op);
        state_t target;
        case (op)
            RTYPE:   target = S_EXEC;
            LW, SW:  target = S_MEMADDR;
            BEQ:     target = S_BRANCH;
            ADDI:    target = S_IEXEC;
            J:       target = S_JUMP;
            default: target = S_IDLE;
        endcase
        return target;
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        return (op == RTYPE) || (op == LW) || (op == SW) ||
               (op == BEQ) || (op == ADDI) || (op == J);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait-state counter: counts cycles spent in a memory state and flags
// the cycle on which the access completes.
module mc_wait_counter #(
    parameter int MEM_LATENCY = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [3:0] LAST_COUNT = 4'(MEM_LATENCY);

    logic [3:0] count_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= 4'd0;
        end else if (clear) begin
            count_reg <= 4'd0;
        end else if (enable) begin
            count_reg <= count_reg + 4'd1;
        end
    end

    assign done = (count_reg == LAST_COUNT);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the datapath strobes and mux selects.
module multi_cycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] Op_i,
    input  logic       Zero_i,
    output logic       PCWrite_o,
    output logic       IRWrite_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       IorD_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] PCSource_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_t state_reg;
    state_t finish_next;
    logic   mem_state;
    logic   wait_done;
    logic   wait_enable;
    logic   wait_clear;

    // The counter only advances while a memory state is still waiting; any
    // other cycle (including the last memory cycle) returns it to zero, so it
    // is always zero on entry to FETCH, MEMREAD or MEMWRITE.
    assign mem_state   = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                         (state_reg == S_MEMWRITE);
    assign wait_enable = mem_state && !wait_done;
    assign wait_clear  = !wait_enable;

    mc_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_wait (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (wait_clear),
        .enable (wait_enable),
        .done   (wait_done)
    );

    assign finish_next = start_i ? S_FETCH : S_IDLE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:     state_reg <= start_i ? S_FETCH : S_IDLE;
                S_FETCH:    state_reg <= wait_done ? S_DECODE : S_FETCH;
                S_DECODE:   state_reg <= op_supported(Op_i) ? decode_target(Op_i) : finish_next;
                S_MEMADDR:  state_reg <= (Op_i == SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_reg <= wait_done ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: state_reg <= wait_done ? finish_next : S_MEMWRITE;
                S_EXEC:     state_reg <= S_RWB;
                S_IEXEC:    state_reg <= S_IWB;
                S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP:
                            state_reg <= finish_next;
                default:    state_reg <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; only DECODE (opcode) and BRANCH
    // (Zero_i) also look at inputs.
    always_comb begin
        PCWrite_o    = 1'b0;
        IRWrite_o    = 1'b0;
        MemRead_o    = 1'b0;
        MemWrite_o   = 1'b0;
        RegWrite_o   = 1'b0;
        RegDst_o     = 1'b0;
        MemtoReg_o   = 1'b0;
        IorD_o       = 1'b0;
        ALUSrcA_o    = 1'b0;
        ALUSrcB_o    = SRCB_REG;
        ALUOp_o      = ALUOP_ADD;
        PCSource_o   = PCSRC_ALU;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead_o = 1'b1;
                if (wait_done) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    ALUSrcB_o = SRCB_FOUR;
                end
            end
            S_DECODE: begin
                ALUSrcB_o = SRCB_IMM_SHIFT;
                if (!op_supported(Op_i)) begin
                    illegal_o    = 1'b1;
                    instr_done_o = 1'b1;
                end
            end
            S_MEMADDR, S_IEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite_o   = 1'b1;
                IorD_o       = 1'b1;
                instr_done_o = wait_done;
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            S_IWB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o    = 1'b1;
                ALUOp_o      = ALUOP_SUB;
                PCSource_o   = PCSRC_ALUOUT;
                PCWrite_o    = Zero_i;
                instr_done_o = 1'b1;
            end
            S_JUMP: begin
                PCSource_o   = PCSRC_JUMP;
                PCWrite_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: one instance with zero memory
// latency and one with two wait cycles, each checked cycle by cycle.
module tb_multi_cycle_control;

    // Output vector order: PCWrite IRWrite MemRead MemWrite RegWrite RegDst
    // MemtoReg IorD ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] instr_done illegal
    localparam logic [16:0] O_IDLE = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] O_FW   = 17'b0_0_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] O_FL   = 17'b1_1_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] O_DEC  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [16:0] O_ILL  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_1;
    localparam logic [16:0] O_MA   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [16:0] O_MR   = 17'b0_0_1_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [16:0] O_MWB  = 17'b0_0_0_0_1_0_1_0_0_00_00_00_1_0;
    localparam logic [16:0] O_MWW  = 17'b0_0_0_1_0_0_0_1_0_00_00_00_0_0;
    localparam logic [16:0] O_MWL  = 17'b0_0_0_1_0_0_0_1_0_00_00_00_1_0;
    localparam logic [16:0] O_EX   = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [16:0] O_RWB  = 17'b0_0_0_0_1_1_0_0_0_00_00_00_1_0;
    localparam logic [16:0] O_IWB  = 17'b0_0_0_0_1_0_0_0_0_00_00_00_1_0;
    localparam logic [16:0] O_BT   = 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] O_BN   = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] O_JMP  = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0;
    logic       start2 = 1'b0;
    logic       zero = 1'b0;
    logic [5:0] op = 6'd0;

    logic       pcw0, irw0, mr0, mw0, rw0, rd0, m2r0, iord0, asa0, done0, ill0;
    logic [1:0] asb0, aop0, pcs0;
    logic [3:0] st0;
    logic       pcw2, irw2, mr2, mw2, rw2, rd2, m2r2, iord2, asa2, done2, ill2;
    logic [1:0] asb2, aop2, pcs2;
    logic [3:0] st2;
    logic [16:0] out0, out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign out0 = {pcw0, irw0, mr0, mw0, rw0, rd0, m2r0, iord0, asa0, asb0, aop0, pcs0, done0, ill0};
    assign out2 = {pcw2, irw2, mr2, mw2, rw2, rd2, m2r2, iord2, asa2, asb2, aop2, pcs2, done2, ill2};

    multi_cycle_control #(.MEM_LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .Op_i(op), .Zero_i(zero),
        .PCWrite_o(pcw0), .IRWrite_o(irw0), .MemRead_o(mr0), .MemWrite_o(mw0),
        .RegWrite_o(rw0), .RegDst_o(rd0), .MemtoReg_o(m2r0), .IorD_o(iord0),
        .ALUSrcA_o(asa0), .ALUSrcB_o(asb0), .ALUOp_o(aop0), .PCSource_o(pcs0),
        .state_o(st0), .instr_done_o(done0), .illegal_o(ill0)
    );

    multi_cycle_control #(.MEM_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .Op_i(op), .Zero_i(zero),
        .PCWrite_o(pcw2), .IRWrite_o(irw2), .MemRead_o(mr2), .MemWrite_o(mw2),
        .RegWrite_o(rw2), .RegDst_o(rd2), .MemtoReg_o(m2r2), .IorD_o(iord2),
        .ALUSrcA_o(asa2), .ALUSrcB_o(asb2), .ALUOp_o(aop2), .PCSource_o(pcs2),
        .state_o(st2), .instr_done_o(done2), .illegal_o(ill2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        op = 6'b000000;
        start0 = 1'b1;
        start2 = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (st0 !== 4'd0 || out0 !== O_IDLE || st2 !== 4'd0 || out2 !== O_IDLE) begin
            errors++;
            $display("FAIL reset_async: st0=%0d out0=%b st2=%0d out2=%b, expected 0 and all-zero", st0, out0, st2, out2);
        end
        tick();
        checks++;
        if (st0 !== 4'd0 || out0 !== O_IDLE) begin
            errors++;
            $display("FAIL reset_held_edge: st0=%0d out0=%b, expected 0 and all-zero", st0, out0);
        end
        #3;
        start0 = 1'b0;
        start2 = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (st0 !== 4'd0 || out0 !== O_IDLE) begin
            errors++;
            $display("FAIL idle_no_start: st0=%0d out0=%b, expected 0 and all-zero", st0, out0);
        end
        start0 = 1'b1;
        tick();
        checks++;
        if (st0 !== 4'd1 || out0 !== O_FL) begin
            errors++;
            $display("FAIL idle_to_fetch: st0=%0d out0=%b, expected 1 and %b", st0, out0, O_FL);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4];
        logic [16:0] eo [4];
        es = '{4'd1, 4'd2, 4'd7, 4'd8};
        eo = '{O_FL, O_DEC, O_EX, O_RWB};
        do_reset();
        op = 6'b000000;
        start0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (st0 !== es[i] || out0 !== eo[i]) begin
                errors++;
                $display("FAIL rtype_cycle%0d: state=%0d out=%b, expected state=%0d out=%b", i + 1, st0, out0, es[i], eo[i]);
            end
        end
        tick();
        checks++;
        if (st0 !== 4'd1) begin
            errors++;
            $display("FAIL rtype_back_to_back: state=%0d, expected 1", st0);
        end
    endtask

    task automatic test_addi();
        logic [3:0]  es [4];
        logic [16:0] eo [4];
        es = '{4'd1, 4'd2, 4'd11, 4'd12};
        eo = '{O_FL, O_DEC, O_MA, O_IWB};
        do_reset();
        op = 6'b001000;
        start0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (st0 !== es[i] || out0 !== eo[i]) begin
                errors++;
                $display("FAIL addi_cycle%0d: state=%0d out=%b, expected state=%0d out=%b", i + 1, st0, out0, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0]  es [3];
        logic [16:0] eo [3];
        es = '{4'd1, 4'd2, 4'd9};
        eo = '{O_FL, O_DEC, O_BT};
        do_reset();
        op = 6'b000100;
        zero = 1'b1;
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st0 !== es[i] || out0 !== eo[i]) begin
                errors++;
                $display("FAIL beq_taken_cycle%0d: state=%0d out=%b, expected state=%0d out=%b", i + 1, st0, out0, es[i], eo[i]);
            end
        end
        zero = 1'b0;
        #1;
        checks++;
        if (out0 !== O_BN) begin
            errors++;
            $display("FAIL beq_not_taken: out=%b, expected %b", out0, O_BN);
        end
        start0 = 1'b0;
        tick();
        checks++;
        if (st0 !== 4'd0 || out0 !== O_IDLE) begin
            errors++;
            $display("FAIL beq_to_idle: state=%0d out=%b, expected 0 and all-zero", st0, out0);
        end
    endtask

    task automatic test_jump();
        logic [3:0]  es [3];
        logic [16:0] eo [3];
        es = '{4'd1, 4'd2, 4'd10};
        eo = '{O_FL, O_DEC, O_JMP};
        do_reset();
        op = 6'b000010;
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st0 !== es[i] || out0 !== eo[i]) begin
                errors++;
                $display("FAIL jump_cycle%0d: state=%0d out=%b, expected state=%0d out=%b", i + 1, st0, out0, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        op = 6'b111111;
        start0 = 1'b1;
        tick();
        tick();
        checks++;
        if (st0 !== 4'd2 || out0 !== O_ILL) begin
            errors++;
            $display("FAIL illegal_decode: state=%0d out=%b, expected state=2 out=%b", st0, out0, O_ILL);
        end
        tick();
        checks++;
        if (st0 !== 4'd1) begin
            errors++;
            $display("FAIL illegal_next: state=%0d, expected 1", st0);
        end
    endtask

    task automatic test_lw_latency();
        logic [3:0]  es [9];
        logic [16:0] eo [9];
        es = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
        eo = '{O_FW, O_FW, O_FL, O_DEC, O_MA, O_MR, O_MR, O_MR, O_MWB};
        do_reset();
        op = 6'b100011;
        start2 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) start2 = 1'b0;
            checks++;
            if (st2 !== es[i] || out2 !== eo[i]) begin
                errors++;
                $display("FAIL lw_l2_cycle%0d: state=%0d out=%b, expected state=%0d out=%b", i + 1, st2, out2, es[i], eo[i]);
            end
        end
        tick();
        checks++;
        if (st2 !== 4'd0) begin
            errors++;
            $display("FAIL lw_l2_to_idle: state=%0d, expected 0", st2);
        end
    endtask

    task automatic test_sw_start_drop();
        logic [3:0]  es [8];
        logic [16:0] eo [8];
        es = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6};
        eo = '{O_FW, O_FW, O_FL, O_DEC, O_MA, O_MWW, O_MWW, O_MWL};
        do_reset();
        op = 6'b101011;
        start2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) start2 = 1'b0;
            checks++;
            if (st2 !== es[i] || out2 !== eo[i]) begin
                errors++;
                $display("FAIL sw_drop_cycle%0d: state=%0d out=%b, expected state=%0d out=%b", i + 1, st2, out2, es[i], eo[i]);
            end
        end
        tick();
        checks++;
        if (st2 !== 4'd0) begin
            errors++;
            $display("FAIL sw_drop_to_idle: state=%0d, expected 0", st2);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] es [4];
        es = '{4'd1, 4'd1, 4'd1, 4'd2};
        do_reset();
        op = 6'b100011;
        start2 = 1'b1;
        repeat (6) tick();
        checks++;
        if (st2 !== 4'd4 || mr2 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_memread: state=%0d MemRead=%b, expected 4 and 1", st2, mr2);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (st2 !== 4'd0 || mr2 !== 1'b0 || out2 !== O_IDLE) begin
            errors++;
            $display("FAIL mid_reset_async: state=%0d MemRead=%b out=%b, expected 0, 0, all-zero", st2, mr2, out2);
        end
        #3;
        rst = 1'b0;
        start2 = 1'b0;
        tick();
        checks++;
        if (st2 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_stay_idle: state=%0d, expected 0", st2);
        end
        start2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (st2 !== es[i]) begin
                errors++;
                $display("FAIL mid_refetch_cycle%0d: state=%0d, expected %0d", i + 1, st2, es[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_branch();
        test_jump();
        test_illegal();
        test_lw_latency();
        test_sw_start_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 0: extra wait cycles per memory access (0..15).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  run enable; level-sensitive.
REQ-005 SHALL have port Op_i  input  6  opcode from the instruction register, inst[31:26].
REQ-006 SHALL have port Zero_i  input  1  ALU zero flag.
REQ-007 SHALL have ports PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o, RegDst_o, MemtoReg_o, IorD_o, ALUSrcA_o  output  1 each  datapath strobes/selects.
REQ-008 SHALL have ports ALUSrcB_o, ALUOp_o, PCSource_o  output  2 each  datapath selects.
REQ-009 SHALL have ports state_o  output  4  current state; instr_done_o  output  1  retire pulse; illegal_o  output  1  unsupported-opcode pulse.

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12; codes 13-15 SHALL go to IDLE next cycle.
REQ-011 SHALL go IDLE->FETCH when start_i=1; otherwise remain in IDLE.
REQ-012 SHALL hold FETCH, MEMREAD and MEMWRITE for exactly MEM_LATENCY+1 cycles, using a 4-bit wait counter that is cleared on entry to each of these states.
REQ-013 FETCH: MemRead_o=1 and IorD_o=0 on every cycle; on the final cycle only, IRWrite_o=1, PCWrite_o=1, ALUSrcA_o=0, ALUSrcB_o=01, ALUOp_o=00 and PCSource_o=00 (PC+4); then go to DECODE.
REQ-014 DECODE: ALUSrcA_o=0, ALUSrcB_o=11, ALUOp_o=00 (branch target); next state by opcode: 000000->EXEC, 100011/101011->MEMADDR, 000100->BRANCH, 001000->IEXEC, 000010->JUMP.
REQ-015 Any other opcode in DECODE SHALL pulse illegal_o and instr_done_o for one cycle and end the instruction (no register, memory or PC write).
REQ-016 MEMADDR: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=00; next state MEMREAD for lw, MEMWRITE for sw.
REQ-017 MEMREAD: MemRead_o=1 and IorD_o=1 on every cycle; then MEMWB.
REQ-018 MEMWB: RegWrite_o=1, MemtoReg_o=1, RegDst_o=0; this is a final state.
REQ-019 MEMWRITE: MemWrite_o=1 and IorD_o=1 on every cycle; the final cycle is the final state of sw.
REQ-020 EXEC: ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=10; then RWB. RWB: RegWrite_o=1, RegDst_o=1, MemtoReg_o=0; final state.
REQ-021 IEXEC: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=00; then IWB. IWB: RegWrite_o=1, RegDst_o=0, MemtoReg_o=0; final state.
REQ-022 BRANCH: ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=01, PCSource_o=01; PCWrite_o=Zero_i (the only Mealy output); final state.
REQ-023 JUMP: PCSource_o=10, PCWrite_o=1; final state.
REQ-024 On the last cycle of every final state, instr_done_o SHALL be 1 for exactly one cycle; next state is FETCH if start_i=1, else IDLE. start_i falling mid-instruction SHALL NOT abort the instruction.
REQ-025 Every output not listed for a state SHALL be 0; in IDLE all outputs SHALL be 0 except state_o.
REQ-026 Latencies with L=MEM_LATENCY: R-type/addi 4+L, beq/j 3+L, sw 4+2L, lw 5+2L cycles from FETCH entry to instr_done_o inclusive.

Reset
REQ-027 rst_i=1 SHALL force state IDLE and clear the wait counter immediately, independent of the clock; all outputs SHALL read 0 while rst_i=1.
REQ-028 Reset asserted mid-instruction SHALL discard that instruction; after release, FETCH SHALL be entered only on a clock edge with start_i=1.

Structure
REQ-029 State codes, opcode constants (RTYPE, LW, SW, BEQ, ADDI, J) and ALUOp codes SHALL live in shared package cpu_ctrl_pkg.
REQ-030 The wait counter SHALL be sub-module mc_wait_counter (clear, enable, done = count==MEM_LATENCY).

Verification
REQ-031 L=0, start_i=1, Op_i=000000: states 1,2,7,8; RegWrite_o=1 and RegDst_o=1 in cycle 4; instr_done_o in cycle 4.
REQ-032 L=2, Op_i=100011: FETCH 3 cycles, IRWrite_o only in the 3rd; MEMREAD 3 cycles; instr_done_o in cycle 9.
REQ-033 Op_i=000100: Zero_i=1 -> PCWrite_o=1, PCSource_o=01 in BRANCH; Zero_i=0 -> PCWrite_o=0.
REQ-034 Op_i=111111: illegal_o=1 in DECODE, no write strobes, next state FETCH.
REQ-035 start_i dropped during MEMADDR of sw: sw completes (MemWrite_o asserted), then IDLE.
REQ-036 rst_i pulsed between clock edges during MEMREAD: state_o=0 and MemRead_o=0 before the next edge.
